// File: rtl/multi_ch_burst_gen_pkg.sv
// Shared types for the multi-channel burst generator: FSM states, lane and
// configuration types sized for the default build.
package mcbg_pkg;

    localparam int DEF_DW  = 4;
    localparam int DEF_NCH = 2;
    localparam int DEF_LW  = 8;
    localparam int DEF_MBW = 4;

    typedef enum logic [1:0] {IDLE, BURST, GAP, FIN} state_t;

    typedef logic [DEF_DW-1:0] lane_t;
    typedef lane_t [DEF_NCH-1:0] lanes_t;

    // Field "rpt" holds the repeat count ("repeat" is a reserved word).
    typedef struct packed {
        lane_t              base;
        lane_t              step;
        lane_t              lane_ofs;
        logic [DEF_LW-1:0]  len;
        logic [DEF_LW-1:0]  gap;
        logic [DEF_MBW-1:0] rpt;
    } cfg_t;

endpackage

// File: rtl/multi_ch_burst_gen_if.sv
// Handshake, configuration and status bundle between the burst generator
// (master) and its consumer/controller (slave).
interface multi_ch_burst_gen_if
    import mcbg_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int NCH          = DEF_NCH,
    parameter int LW           = DEF_LW,
    parameter int MAX_BURSTS_W = DEF_MBW
);
    logic                    start;
    logic [DW-1:0]           cfg_base;
    logic [DW-1:0]           cfg_step;
    logic [DW-1:0]           cfg_lane_ofs;
    logic [LW-1:0]           cfg_len;
    logic [LW-1:0]           cfg_gap;
    logic [MAX_BURSTS_W-1:0] cfg_repeat;
    logic                    o_valid;
    logic                    o_ready;
    logic [NCH*DW-1:0]       o_data;
    logic                    o_last;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, cfg_base, cfg_step, cfg_lane_ofs, cfg_len, cfg_gap, cfg_repeat, o_ready,
        output o_valid, o_data, o_last, busy, done
    );

    modport slave (
        output start, cfg_base, cfg_step, cfg_lane_ofs, cfg_len, cfg_gap, cfg_repeat, o_ready,
        input  o_valid, o_data, o_last, busy, done
    );
endinterface

// File: rtl/multi_ch_burst_gen_lane_calc.sv
// Registered per-lane values: lane c = lane0 + c*ofs, wrapping at DW bits.
module mcbg_lane_calc #(
    parameter int DW  = 4,
    parameter int NCH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW-1:0]           lane0,
    input  logic [DW-1:0]           ofs,
    output logic [NCH-1:0][DW-1:0]  lanes
);
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        localparam logic [DW-1:0] CK = DW'(c);
        always_ff @(posedge clk) begin
            if (rst) lanes[c] <= '0;
            else     lanes[c] <= lane0 + DW'(ofs * CK);
        end
    end
endmodule

// File: rtl/multi_ch_burst_gen.sv
// Multi-lane counting burst source: bursts of cfg_len beats, cfg_gap idle
// cycles between bursts, cfg_repeat extra bursts, valid/ready output.
module multi_ch_burst_gen
    import mcbg_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int NCH          = DEF_NCH,
    parameter int LW           = DEF_LW,
    parameter int MAX_BURSTS_W = DEF_MBW
) (
    input logic                 clk,
    input logic                 rst,
    multi_ch_burst_gen_if.master bus
);
    typedef struct packed {
        logic [DW-1:0] step;
        logic [DW-1:0] lane_ofs;
        logic [LW-1:0] len;
        logic [LW-1:0] gap;
    } run_cfg_t;

    state_t                  state, state_nxt;
    run_cfg_t                cfg_q, cfg_nxt;
    logic [DW-1:0]           lane0, lane0_nxt;
    logic [LW-1:0]           beat_cnt, beat_cnt_nxt;
    logic [LW-1:0]           gap_cnt, gap_cnt_nxt;
    logic [MAX_BURSTS_W-1:0] bursts_left, bursts_left_nxt;
    logic [NCH-1:0][DW-1:0]  lanes;
    logic                    accept, last_beat;

    assign accept    = (state == BURST) && bus.o_ready;
    assign last_beat = (beat_cnt == cfg_q.len - LW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cfg_q       <= '0;
            lane0       <= '0;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            bursts_left <= '0;
        end else begin
            state       <= state_nxt;
            cfg_q       <= cfg_nxt;
            lane0       <= lane0_nxt;
            beat_cnt    <= beat_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            bursts_left <= bursts_left_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cfg_nxt         = cfg_q;
        lane0_nxt       = lane0;
        beat_cnt_nxt    = beat_cnt;
        gap_cnt_nxt     = gap_cnt;
        bursts_left_nxt = bursts_left;
        case (state)
            IDLE: if (bus.start) begin
                cfg_nxt         = '{step: bus.cfg_step, lane_ofs: bus.cfg_lane_ofs,
                                    len: bus.cfg_len, gap: bus.cfg_gap};
                lane0_nxt       = bus.cfg_base;
                beat_cnt_nxt    = '0;
                gap_cnt_nxt     = '0;
                bursts_left_nxt = bus.cfg_repeat;
                state_nxt       = (bus.cfg_len == '0) ? FIN : BURST;
            end
            BURST: if (accept) begin
                lane0_nxt    = lane0 + cfg_q.step;
                beat_cnt_nxt = beat_cnt + LW'(1);
                if (last_beat) begin
                    beat_cnt_nxt = '0;
                    if (bursts_left == '0) begin
                        state_nxt = FIN;
                    end else begin
                        bursts_left_nxt = bursts_left - MAX_BURSTS_W'(1);
                        // gap==0 keeps us in BURST: next burst follows with no bubble
                        if (cfg_q.gap != '0) begin
                            state_nxt   = GAP;
                            gap_cnt_nxt = cfg_q.gap - LW'(1);
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = BURST;
                else               gap_cnt_nxt = gap_cnt - LW'(1);
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fed with next-state values so lane data lines up with o_valid.
    mcbg_lane_calc #(.DW(DW), .NCH(NCH)) u_lane_calc (
        .clk   (clk),
        .rst   (rst),
        .lane0 (lane0_nxt),
        .ofs   (cfg_nxt.lane_ofs),
        .lanes (lanes)
    );

    assign bus.o_data  = lanes;
    assign bus.o_valid = (state == BURST);
    assign bus.o_last  = (state == BURST) && last_beat;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == FIN);
endmodule

// File: tb/tb_multi_ch_burst_gen.sv
// Randomized self-checking bench for multi_ch_burst_gen against a beat-list model.
module tb_multi_ch_burst_gen;
    import mcbg_pkg::*;

    localparam int DW  = DEF_DW;
    localparam int NCH = DEF_NCH;
    localparam int LW  = DEF_LW;
    localparam int MBW = DEF_MBW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    multi_ch_burst_gen_if #(.DW(DW), .NCH(NCH), .LW(LW), .MAX_BURSTS_W(MBW)) bus ();

    multi_ch_burst_gen #(.DW(DW), .NCH(NCH), .LW(LW), .MAX_BURSTS_W(MBW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [NCH*DW-1:0] exp_data[$];
    bit                exp_last[$];

    function automatic logic [NCH*DW-1:0] pack_lanes(int l0, int ofs);
        logic [NCH*DW-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c*DW +: DW] = DW'((l0 + c * ofs) % (1 << DW));
        return v;
    endfunction

    // Expected accepted-beat list: beat k of the sequence carries base + k*step.
    task automatic build_model(input cfg_t c);
        int k;
        exp_data.delete();
        exp_last.delete();
        for (int b = 0; b <= int'(c.rpt); b++)
            for (int i = 0; i < int'(c.len); i++) begin
                k = b * int'(c.len) + i;
                exp_data.push_back(pack_lanes((int'(c.base) + k * int'(c.step)) % (1 << DW), int'(c.lane_ofs)));
                exp_last.push_back(i == int'(c.len) - 1);
            end
    endtask

    task automatic drive_cfg(input cfg_t c);
        bus.cfg_base     = c.base;
        bus.cfg_step     = c.step;
        bus.cfg_lane_ofs = c.lane_ofs;
        bus.cfg_len      = c.len;
        bus.cfg_gap      = c.gap;
        bus.cfg_repeat   = c.rpt;
    endtask

    function automatic cfg_t mk_cfg(int base, int step, int ofs, int len, int gap, int rpt);
        cfg_t c;
        c.base     = lane_t'(base);
        c.step     = lane_t'(step);
        c.lane_ofs = lane_t'(ofs);
        c.len      = LW'(len);
        c.gap      = LW'(gap);
        c.rpt      = MBW'(rpt);
        return c;
    endfunction

    // rmode: 0 ready always high, 1 pattern 1,0,0,1,..., 2 random.
    // poke>0: pulse start with scrambled cfg at that cycle and again during FIN.
    task automatic run_seq(input string name, input cfg_t c, input int rmode, input int poke);
        int cyc, idx, gapc, last_acc;
        bit pend_gap, done_seen, r;
        build_model(c);
        drive_cfg(c);
        @(negedge clk);
        bus.start = 1'b1;
        cyc = 0; idx = 0; gapc = 0; last_acc = 0; pend_gap = 0; done_seen = 0;
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (poke > 0 && cyc == poke) begin
                bus.start        = 1'b1;
                bus.cfg_base     = lane_t'($urandom);
                bus.cfg_step     = lane_t'($urandom);
                bus.cfg_lane_ofs = lane_t'($urandom);
                bus.cfg_len      = LW'($urandom_range(1, 9));
                bus.cfg_gap      = LW'($urandom_range(0, 3));
                bus.cfg_repeat   = MBW'($urandom_range(0, 3));
            end
            case (rmode)
                0:       r = 1'b1;
                1:       r = ((cyc % 3) == 1);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.o_ready = r;
            if (cyc == 1) begin
                n_checks++;
                if (bus.o_valid !== (c.len != 0)) begin
                    n_fail++;
                    $display("FAIL %s first_valid got %b exp %b", name, bus.o_valid, c.len != 0);
                end
            end
            if (bus.o_valid === 1'b1) begin
                if (pend_gap) begin
                    n_checks++;
                    if (gapc != int'(c.gap)) begin
                        n_fail++;
                        $display("FAIL %s gap_len got %0d exp %0d", name, gapc, c.gap);
                    end
                    pend_gap = 0;
                end
                n_checks++;
                if (idx >= exp_data.size()) begin
                    n_fail++;
                    $display("FAIL %s extra_beat got data %h exp no beat", name, bus.o_data);
                end else begin
                    if (bus.o_data !== exp_data[idx] || bus.o_last !== exp_last[idx]) begin
                        n_fail++;
                        $display("FAIL %s beat%0d got data %h last %b exp data %h last %b",
                                 name, idx, bus.o_data, bus.o_last, exp_data[idx], exp_last[idx]);
                    end
                    if (r) begin
                        if (exp_last[idx] && idx + 1 < exp_data.size()) begin
                            pend_gap = 1;
                            gapc = 0;
                        end
                        last_acc = cyc;
                        idx++;
                    end
                end
            end else if (pend_gap) begin
                gapc++;
            end
            if (bus.done === 1'b1) begin
                done_seen = 1;
                n_checks++;
                if (idx != exp_data.size() || bus.busy !== 1'b1 ||
                    cyc != ((exp_data.size() == 0) ? 1 : last_acc + 1)) begin
                    n_fail++;
                    $display("FAIL %s done_timing got cyc %0d beats %0d busy %b exp cyc %0d beats %0d busy 1",
                             name, cyc, idx, bus.busy,
                             (exp_data.size() == 0) ? 1 : last_acc + 1, exp_data.size());
                end
                if (poke > 0) bus.start = 1'b1;
            end
        end
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout got no done exp done within 3000 cycles", name);
        end
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_done got done %b busy %b valid %b exp 0 0 0",
                     name, bus.done, bus.busy, bus.o_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.o_data !== '0) begin
            n_fail++;
            $display("FAIL reset got valid %b last %b busy %b done %b data %h exp all 0",
                     bus.o_valid, bus.o_last, bus.busy, bus.done, bus.o_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        run_seq("single", mk_cfg(0, 1, 0, 10, 0, 0), 0, 0);
    endtask

    task automatic test_backpressure();
        run_seq("backpressure", mk_cfg(0, 1, 0, 4, 0, 0), 1, 0);
    endtask

    task automatic test_repeat_gap();
        run_seq("repeat_gap", mk_cfg(0, 2, 0, 3, 2, 2), 0, 0);
    endtask

    task automatic test_multi_lane();
        run_seq("multi_lane", mk_cfg(5, 1, 3, 2, 0, 0), 0, 0);
        run_seq("multi_lane_wrap", mk_cfg(14, 1, 3, 2, 0, 0), 0, 0);
    endtask

    task automatic test_edge_cases();
        run_seq("len_zero", mk_cfg(7, 1, 1, 0, 0, 0), 0, 0);
        run_seq("start_busy", mk_cfg(2, 3, 5, 6, 1, 1), 2, 3);
    endtask

    task automatic test_back_to_back();
        run_seq("back_to_back", mk_cfg(9, 1, 2, 3, 0, 1), 0, 0);
    endtask

    task automatic test_reset_mid();
        cfg_t c;
        c = mk_cfg(3, 1, 4, 8, 1, 1);
        drive_cfg(c);
        @(negedge clk);
        bus.start = 1'b1;
        bus.o_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got valid %b busy %b done %b exp 0 0 0",
                     bus.o_valid, bus.busy, bus.done);
        end
        rst = 1'b0;
        run_seq("replay", c, 0, 0);
    endtask

    task automatic test_random();
        cfg_t c;
        for (int t = 0; t < 15; t++) begin
            c = mk_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3));
            run_seq("random", c, 2, 0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.o_ready = 1'b0;
        drive_cfg('0);
        test_reset();
        test_single_burst();
        test_backpressure();
        test_repeat_gap();
        test_multi_lane();
        test_edge_cases();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
